// File: rtl/atom_mem_arbiter.sv
// Two-to-one IMEM/DMEM arbiter onto one valid/ack memory port, with an optional no-ack watchdog.
// Define ATOM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise DMEM has fixed priority.
module atom_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_addr_i,
   output logic [31:0] imem_data_o,
   output logic        imem_ack_o,
   input  logic        dmem_valid_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_data_i,
   input  logic [3:0]  dmem_sel_i,
   input  logic        dmem_we_i,
   output logic [31:0] dmem_data_o,
   output logic        dmem_ack_o,
   output logic        mem_valid_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [3:0]  mem_sel_o,
   output logic        mem_we_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   output logic        timeout_o
);

   localparam int unsigned CNT_W = 16;
   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              expire_c;
   logic              prefer_dmem_c;

   // Watchdog fires on the last allowed BUSY cycle; a real ack in that cycle wins.
   assign expire_c = WDOG_EN && (state_q != IDLE) && !mem_ack_i && (cnt_q == LAST_CNT);

`ifdef ATOM_ARB_ROUND_ROBIN_EN
   logic last_dmem_q, last_dmem_d;

   always_comb begin
      last_dmem_d = last_dmem_q;
      if (state_q == IDLE && state_d != IDLE) begin
         last_dmem_d = (state_d == BUSY_D);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_dmem_q <= 1'b0;
      end else begin
         last_dmem_q <= last_dmem_d;
      end
   end

   assign prefer_dmem_c = ~last_dmem_q;
`else
   assign prefer_dmem_c = 1'b1;
`endif

   // Next state and watchdog count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (imem_valid_i && dmem_valid_i) begin
               state_d = prefer_dmem_c ? BUSY_D : BUSY_I;
            end else if (imem_valid_i) begin
               state_d = BUSY_I;
            end else if (dmem_valid_i) begin
               state_d = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack_i || expire_c) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Port steering decoded from the registered grant state
   always_comb begin
      mem_valid_o = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      mem_sel_o   = '0;
      mem_we_o    = 1'b0;
      imem_ack_o  = 1'b0;
      imem_data_o = '0;
      dmem_ack_o  = 1'b0;
      dmem_data_o = '0;
      timeout_o   = expire_c;
      case (state_q)
         BUSY_I: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = imem_addr_i;
            mem_sel_o   = 4'hF;
            imem_ack_o  = mem_ack_i | expire_c;
            imem_data_o = expire_c ? 32'h0 : mem_data_i;
         end
         BUSY_D: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = dmem_addr_i;
            mem_data_o  = dmem_data_i;
            mem_sel_o   = dmem_sel_i;
            mem_we_o    = dmem_we_i;
            dmem_ack_o  = mem_ack_i | expire_c;
            dmem_data_o = expire_c ? 32'h0 : mem_data_i;
         end
         default: begin
            timeout_o = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/atom_mem_arbiter.md
# atom_mem_arbiter

Two-to-one memory port arbiter that lets the AtomRV core's instruction port (IMEM) and data port (DMEM) share a single memory/bus port using the core's valid/ack handshake. It sits between the core wrapper and a unified memory or bus slave. It grants one requester at a time through an IDLE/BUSY state machine and forwards address, data and ack for the granted side. An optional watchdog ends transactions the slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, 0, number of BUSY cycles without `mem_ack_i` before forced termination; 0 disables the watchdog.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- imem_valid_i  input  1  IMEM request.
- imem_addr_i  input  32  IMEM address.
- imem_data_o  output  32  IMEM read data.
- imem_ack_o  output  1  IMEM ack.
- dmem_valid_i  input  1  DMEM request.
- dmem_addr_i  input  32  DMEM address.
- dmem_data_i  input  32  DMEM write data.
- dmem_sel_i  input  4  DMEM byte select.
- dmem_we_i  input  1  DMEM write enable.
- dmem_data_o  output  32  DMEM read data.
- dmem_ack_o  output  1  DMEM ack.
- mem_valid_o  output  1  shared-port request.
- mem_addr_o  output  32  shared-port address.
- mem_data_o  output  32  shared-port write data.
- mem_sel_o  output  4  shared-port byte select.
- mem_we_o  output  1  shared-port write enable.
- mem_data_i  input  32  shared-port read data.
- mem_ack_i  input  1  shared-port ack.
- timeout_o  output  1  one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- IDLE:
  - Only `imem_valid_i` high -> BUSY_I.
  - Only `dmem_valid_i` high -> BUSY_D.
  - Both high -> arbitration policy (see Configuration).
  - Neither high -> stay in IDLE.
- BUSY_I: mem_* request outputs carry the IMEM request with `mem_sel_o`=4'hF, `mem_we_o`=0, `mem_data_o`=0. `imem_ack_o`=`mem_ack_i`, `imem_data_o`=`mem_data_i`.
- BUSY_D: mem_* request outputs carry the DMEM request. `dmem_ack_o`=`mem_ack_i`, `dmem_data_o`=`mem_data_i`.
- Non-granted side: ack=0, data=0.
- In IDLE: `mem_valid_o`, `mem_addr_o`, `mem_data_o`, `mem_sel_o`, `mem_we_o` are all 0, and both acks are 0.
- BUSY_x + `mem_ack_i` -> IDLE. Exactly one transaction per grant.
- Requesters must hold valid and request fields stable until their ack. If the granted requester drops valid while in BUSY, the arbiter still holds `mem_valid_o` until `mem_ack_i` or timeout. That ack is still forwarded.
- Watchdog (TIMEOUT_CYCLES>0):
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, that cycle asserts the granted side's ack with data 0 and pulses `timeout_o`. State -> IDLE.
  - A real `mem_ack_i` in the same cycle takes precedence: normal ack with real data, no `timeout_o`.
- `mem_ack_i` in IDLE is ignored.

## Timing
- Request sampled in IDLE at edge N; `mem_valid_o` high from cycle N+1 (one cycle grant latency).
- Ack is combinational from `mem_ack_i` to the granted side's ack, no added latency. Data is combinational from `mem_data_i`.
- At least one IDLE cycle separates consecutive grants, so peak throughput is one transaction per 2 cycles with a zero-wait slave.
- Reset asserted mid-transaction: state -> IDLE immediately (async). All outputs as in IDLE, counter 0, last-grant register = IMEM.

## Configuration
- `ATOM_ARB_ROUND_ROBIN_EN` defined: on contention, grant the side not granted last. The last-grant register updates on every grant and resets to IMEM, so the first contention goes to DMEM.
- Not defined: fixed priority, DMEM always wins contention. The last-grant register is not implemented.

## Test plan
- Single IMEM read: imem_valid_i=1, addr 0x100; slave acks 2 cycles after `mem_valid_o` with data 0xDEADBEEF -> `mem_addr_o`=0x100, sel=F, we=0; imem_ack_o/imem_data_o=0xDEADBEEF in the ack cycle; dmem_ack_o stays 0.
- DMEM write: addr 0x2000, data 0x12345678, sel 4'b0011, we=1 -> identical values on mem_*, dmem_ack_o follows mem_ack_i, imem side idle.
- Contention, both valid every cycle, zero-wait slave, 6 grants -> macro off: all 6 DMEM; macro on: D,I,D,I,D,I.
- Watchdog: TIMEOUT_CYCLES=8, slave never acks -> after 8 BUSY cycles the granted ack is asserted with data 0 and timeout_o pulses once; next request is served normally.
- Ack and expiry in the same cycle -> real data returned, timeout_o stays 0.
- Reset (rst_ni low) while in BUSY_D -> mem_valid_o=0 asynchronously; after release, a pending IMEM request is granted first in both configurations.
